// File: rtl/chacha_round_sched.sv
`timescale 1ns/1ps
// Round scheduler for the shared ChaCha quarter-round datapath: init strobe,
// ROUNDS column/diagonal quarter-round issues, 16-word feed-forward, done pulse.
//
// state  | meaning
// IDLE   | waiting for start
// INIT   | one-cycle copy of original state into working state
// QR     | issuing quarter-round index sets over valid/ready
// FF     | 16-cycle feed-forward addition, one word per cycle
// DONE   | one-cycle completion pulse
module chacha_round_sched #(
  parameter int ROUNDS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       init,
  output logic       qr_valid,
  input  logic       qr_ready,
  output logic [3:0] qr_a,
  output logic [3:0] qr_b,
  output logic [3:0] qr_c,
  output logic [3:0] qr_d,
  output logic [4:0] round,
  output logic       ff_en,
  output logic [3:0] ff_idx,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_QR,
    S_FF,
    S_DONE
  } state_e;

  localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);

  state_e     state_q, state_d;
  logic [4:0] round_q, round_d;
  logic [1:0] qsel_q, qsel_d;
  logic [3:0] ff_cnt_q, ff_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      round_q  <= '0;
      qsel_q   <= '0;
      ff_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      round_q  <= round_d;
      qsel_q   <= qsel_d;
      ff_cnt_q <= ff_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    round_d  = round_q;
    qsel_d   = qsel_q;
    ff_cnt_d = ff_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_INIT;
      end
      S_INIT: begin
        round_d = '0;
        qsel_d  = '0;
        state_d = S_QR;
      end
      S_QR: begin
        if (qr_ready) begin
          qsel_d = qsel_q + 2'd1;
          if (qsel_q == 2'd3) begin
            if (round_q == LAST_ROUND) begin
              round_d  = '0;
              ff_cnt_d = 4'hF;
              state_d  = S_FF;
            end else begin
              round_d = round_q + 5'd1;
            end
          end
        end
      end
      S_FF: begin
        // Down-counter: word index is its complement, terminal count at zero.
        ff_cnt_d = ff_cnt_q - 4'd1;
        if (ff_cnt_q == 4'd0) begin
          ff_cnt_d = '0;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic [1:0] qsel_p1, qsel_p2, qsel_p3;

  always_comb begin
    qsel_p1 = qsel_q + 2'd1;
    qsel_p2 = qsel_q + 2'd2;
    qsel_p3 = qsel_q + 2'd3;
    qr_a = '0;
    qr_b = '0;
    qr_c = '0;
    qr_d = '0;
    if (state_q == S_QR) begin
      qr_a = {2'b00, qsel_q};
      if (!round_q[0]) begin
        qr_b = {2'b01, qsel_q};
        qr_c = {2'b10, qsel_q};
        qr_d = {2'b11, qsel_q};
      end else begin
        // Diagonal rounds rotate rows 1..3 left by one, two and three columns.
        qr_b = {2'b01, qsel_p1};
        qr_c = {2'b10, qsel_p2};
        qr_d = {2'b11, qsel_p3};
      end
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign init     = (state_q == S_INIT);
  assign qr_valid = (state_q == S_QR);
  assign round    = qr_valid ? round_q : '0;
  assign ff_en    = (state_q == S_FF);
  assign ff_idx   = ff_en ? ~ff_cnt_q : '0;
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_chacha_round_sched.sv
`timescale 1ns/1ps
// Bench for chacha_round_sched: ROUNDS=20 and ROUNDS=2 instances checked
// cycle by cycle against a table-driven reference of the block schedule.
module tb_chacha_round_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_v = 1'b0;
  logic ready_v = 1'b0;
  logic sel = 1'b0;

  always #5 clk = ~clk;

  logic       b20, i20, v20, fe20, d20;
  logic [3:0] a20, bb20, c20, dd20, fi20;
  logic [4:0] r20;
  logic       b2, i2, v2, fe2, d2;
  logic [3:0] a2, bb2, c2, dd2, fi2;
  logic [4:0] r2;

  chacha_round_sched #(.ROUNDS(20)) dut20 (
    .clk(clk), .rst_n(rst_n), .start(start_v & ~sel), .busy(b20), .init(i20),
    .qr_valid(v20), .qr_ready(ready_v), .qr_a(a20), .qr_b(bb20), .qr_c(c20),
    .qr_d(dd20), .round(r20), .ff_en(fe20), .ff_idx(fi20), .done(d20)
  );

  chacha_round_sched #(.ROUNDS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_v & sel), .busy(b2), .init(i2),
    .qr_valid(v2), .qr_ready(ready_v), .qr_a(a2), .qr_b(bb2), .qr_c(c2),
    .qr_d(dd2), .round(r2), .ff_en(fe2), .ff_idx(fi2), .done(d2)
  );

  // {busy, init, qr_valid, a, b, c, d, round, ff_en, ff_idx, done}
  logic [29:0] obs20, obs2, obs;
  assign obs20 = {b20, i20, v20, a20, bb20, c20, dd20, r20, fe20, fi20, d20};
  assign obs2  = {b2, i2, v2, a2, bb2, c2, dd2, r2, fe2, fi2, d2};
  assign obs   = sel ? obs2 : obs20;

  int checks = 0;
  int errors = 0;

  logic [15:0] col_tab[4]  = '{16'h048C, 16'h159D, 16'h26AE, 16'h37BF};
  logic [15:0] diag_tab[4] = '{16'h05AF, 16'h16BC, 16'h278D, 16'h349E};

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic logic [29:0] expv(input bit bz, input bit it, input bit qv,
                                       input logic [15:0] tup, input int rnd,
                                       input bit fe, input int fi, input bit dn);
    return {bz, it, qv, tup, 5'(rnd), fe, 4'(fi), dn};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      check("excl20", 32'(int'(i20) + int'(v20) + int'(fe20) + int'(d20)), 32'(b20));
      check("excl2", 32'(int'(i2) + int'(v2) + int'(fe2) + int'(d2)), 32'(b2));
    end
  end

  // Called at a negedge in an idle cycle (cycle 0); returns at the negedge
  // of the cycle after done.
  task automatic run_block(input int r, input int mode, input bit extra);
    int hs = 0, ffk = 0, stalls = 0, qc = 0;
    int obs_hs = 0, dones = 0, done_cyc = -1, c;
    bit rdy, fin = 0, in_qr;
    logic [15:0] tup;
    logic [29:0] exp;
    check($sformatf("idle_before_r%0d", r), 32'(obs), 32'h0);
    start_v = 1'b1;
    ready_v = 1'b1;
    @(negedge clk);
    start_v = 1'b0;
    c = 1;
    while (!fin && c < 3000) begin
      in_qr = 0;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (qc % 5 == 0) || (qc % 5 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (c == 1) begin
        exp = expv(1, 1, 0, 16'h0, 0, 0, 0, 0);
      end else if (hs < 4 * r) begin
        in_qr = 1;
        tup = ((hs / 4) % 2 == 1) ? diag_tab[hs % 4] : col_tab[hs % 4];
        exp = expv(1, 0, 1, tup, hs / 4, 0, 0, 0);
      end else if (ffk < 16) begin
        exp = expv(1, 0, 0, 16'h0, 0, 1, ffk, 0);
      end else begin
        exp = expv(1, 0, 0, 16'h0, 0, 0, 0, 1);
        fin = 1;
      end
      ready_v = rdy;
      check($sformatf("r%0d_m%0d_cyc%0d", r, mode, c), 32'(obs), 32'(exp));
      if (obs[27] && ready_v) obs_hs++;
      if (obs[0]) begin
        dones++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (in_qr) begin
        if (rdy) hs++;
        else stalls++;
        qc++;
      end else if (c != 1 && !fin) begin
        ffk++;
      end
      start_v = extra && (c == 5 || c == 60 || c == 98);
      @(negedge clk);
      c++;
    end
    start_v = 1'b0;
    check($sformatf("finished_r%0d_m%0d", r, mode), 32'(fin), 32'd1);
    check($sformatf("handshakes_r%0d_m%0d", r, mode), 32'(obs_hs), 32'(4 * r));
    check($sformatf("done_count_r%0d_m%0d", r, mode), 32'(dones), 32'd1);
    check($sformatf("done_cycle_r%0d_m%0d", r, mode), 32'(done_cyc), 32'(4 * r + 18 + stalls));
  endtask

  initial begin
    #1;
    check("reset20", 32'(obs20), 32'h0);
    check("reset2", 32'(obs2), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    sel = 1'b0;
    run_block(20, 0, 0);
    run_block(20, 1, 0);
    run_block(20, 0, 1);
    run_block(20, 0, 0);
    run_block(20, 2, 0);
    sel = 1'b1;
    run_block(2, 0, 0);
    run_block(2, 1, 0);
    run_block(2, 2, 0);
    sel = 1'b0;
    @(negedge clk);

    // Abort mid-QR at round 7, qsel 2 (handshake 30, cycle 32).
    start_v = 1'b1;
    ready_v = 1'b1;
    @(negedge clk);
    start_v = 1'b0;
    repeat (31) @(negedge clk);
    check("pre_abort_state", 32'(obs20), 32'(expv(1, 0, 1, 16'h278D, 7, 0, 0, 0)));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset20", 32'(obs20), 32'h0);
    check("async_reset2", 32'(obs2), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("post_reset_idle_%0d", k), 32'(obs20), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
